// File: rtl/mem_req_arbiter_pkg.sv
// mem_req_arbiter_pkg: source tags and SRAM-like size encodings shared by the arbiter and its tag FIFO
package mem_req_arbiter_pkg;
  localparam logic SRC_INST = 1'b0;
  localparam logic SRC_DATA = 1'b1;
  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;
endpackage

// File: rtl/arb_tag_fifo.sv
// arb_tag_fifo: in-order 1-bit source-tag FIFO (clk, reset, push/din in, pop in, full/empty/head out)
module arb_tag_fifo #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic push,
  input  logic din,
  input  logic pop,
  output logic full,
  output logic empty,
  output logic head
);
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  logic tags [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] cnt;
  logic do_push, do_pop;
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction
  assign full = cnt == CW'(DEPTH);
  assign empty = cnt == '0;
  assign head = tags[rd_ptr];
  assign do_push = push & !full;
  assign do_pop = pop & !empty;
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt <= '0;
    end else begin
      if (do_push) begin
        tags[wr_ptr] <= din;
        wr_ptr <= nxt(wr_ptr);
      end
      if (do_pop) rd_ptr <= nxt(rd_ptr);
      cnt <= cnt + CW'(do_push) - CW'(do_pop);
    end
  end
endmodule

// File: rtl/mem_req_arbiter.sv
// mem_req_arbiter: shares one SRAM-like port between inst/data requesters (inst_*/data_* upstream, mem_* downstream, proto_err sticky stray-response flag)
module mem_req_arbiter
  import mem_req_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int OUTST = 2,
  parameter int STARVE_LIMIT = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              inst_req,
  input  logic              inst_wr,
  input  logic [1:0]        inst_size,
  input  logic [3:0]        inst_wstrb,
  input  logic [ADDR_W-1:0] inst_addr,
  input  logic [DATA_W-1:0] inst_wdata,
  output logic              inst_addr_ok,
  output logic              inst_data_ok,
  output logic [DATA_W-1:0] inst_rdata,
  input  logic              data_req,
  input  logic              data_wr,
  input  logic [1:0]        data_size,
  input  logic [3:0]        data_wstrb,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic              data_addr_ok,
  output logic              data_data_ok,
  output logic [DATA_W-1:0] data_rdata,
  output logic              mem_req,
  output logic              mem_wr,
  output logic [1:0]        mem_size,
  output logic [3:0]        mem_wstrb,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_addr_ok,
  input  logic              mem_data_ok,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              proto_err
);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] SLIM = SW'(STARVE_LIMIT);
  logic lock, lock_src, sel, full, empty, head, hs, rsp;
  logic [SW-1:0] starve_cnt;
  always_comb begin
    sel = lock ? lock_src
        : (starve_cnt == SLIM && inst_req) ? SRC_INST
        : data_req ? SRC_DATA : SRC_INST;
  end
  assign mem_req = (sel == SRC_DATA ? data_req : inst_req) & !full;
  assign mem_wr = sel == SRC_DATA ? data_wr : inst_wr;
  assign mem_size = sel == SRC_DATA ? data_size : inst_size;
  assign mem_wstrb = sel == SRC_DATA ? data_wstrb : inst_wstrb;
  assign mem_addr = sel == SRC_DATA ? data_addr : inst_addr;
  assign mem_wdata = sel == SRC_DATA ? data_wdata : inst_wdata;
  assign hs = mem_req & mem_addr_ok;
  assign inst_addr_ok = hs & (sel == SRC_INST);
  assign data_addr_ok = hs & (sel == SRC_DATA);
  assign rsp = mem_data_ok & !empty;
  assign inst_data_ok = rsp & (head == SRC_INST);
  assign data_data_ok = rsp & (head == SRC_DATA);
  assign inst_rdata = mem_rdata;
  assign data_rdata = mem_rdata;
  arb_tag_fifo #(.DEPTH(OUTST)) u_tags (
    .clk(clk),
    .reset(reset),
    .push(hs),
    .din(sel),
    .pop(rsp),
    .full(full),
    .empty(empty),
    .head(head)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      lock <= 1'b0;
      lock_src <= SRC_INST;
      starve_cnt <= '0;
      proto_err <= 1'b0;
    end else begin
      lock <= mem_req & !mem_addr_ok;
      if (mem_req) lock_src <= sel;
      starve_cnt <= (!inst_req || inst_addr_ok) ? '0 : (starve_cnt == SLIM) ? starve_cnt : starve_cnt + 1'b1;
      if (mem_data_ok && empty) proto_err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_mem_req_arbiter.sv
// tb_mem_req_arbiter: directed scenarios plus randomized traffic checked against a queue-based reference model
module tb_mem_req_arbiter;
  localparam int OUTST = 2;
  localparam int LIM = 8;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic inst_req, inst_wr, data_req, data_wr;
  logic [1:0] inst_size, data_size, mem_size;
  logic [3:0] inst_wstrb, data_wstrb, mem_wstrb;
  logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata, mem_addr, mem_wdata;
  logic inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
  logic [31:0] inst_rdata, data_rdata, mem_rdata;
  logic mem_req, mem_wr, mem_addr_ok, mem_data_ok, proto_err;
  int total = 0;
  int bad = 0;
  bit q[$];
  int starve = 0;
  int held = -1;
  bit perr = 0;
  logic s_iaok, s_daok, s_idok, s_ddok, s_mreq, s_perr;
  logic [31:0] s_maddr, s_irdata;
  always #5 clk = ~clk;
  mem_req_arbiter #(.ADDR_W(32), .DATA_W(32), .OUTST(OUTST), .STARVE_LIMIT(LIM)) dut (
    .clk(clk), .reset(reset),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_wstrb(inst_wstrb),
    .inst_addr(inst_addr), .inst_wdata(inst_wdata), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_wstrb(data_wstrb),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_wstrb(mem_wstrb),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok),
    .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata), .proto_err(proto_err)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic step(input bit ir, input bit dr, input bit maok, input bit mdok, input logic [31:0] rd);
    int s;
    bit full, mreq, pop_i, pop_d;
    inst_req = ir;
    data_req = dr;
    mem_addr_ok = maok;
    mem_data_ok = mdok;
    mem_rdata = rd;
    #1;
    full = q.size() == OUTST;
    s = held >= 0 ? held : (starve == LIM && ir) ? 0 : dr ? 1 : 0;
    mreq = (s == 1 ? dr : ir) && !full;
    pop_i = mdok && q.size() > 0 && q[0] == 1'b0;
    pop_d = mdok && q.size() > 0 && q[0] == 1'b1;
    s_iaok = inst_addr_ok;
    s_daok = data_addr_ok;
    s_idok = inst_data_ok;
    s_ddok = data_data_ok;
    s_mreq = mem_req;
    s_perr = proto_err;
    s_maddr = mem_addr;
    s_irdata = inst_rdata;
    chk("mem_req", mem_req, mreq);
    chk("inst_addr_ok", inst_addr_ok, mreq && maok && s == 0);
    chk("data_addr_ok", data_addr_ok, mreq && maok && s == 1);
    chk("inst_data_ok", inst_data_ok, pop_i);
    chk("data_data_ok", data_data_ok, pop_d);
    chk("proto_err", proto_err, perr);
    if (mreq) begin
      chk("mem_addr", mem_addr, s == 1 ? data_addr : inst_addr);
      chk("mem_wdata", mem_wdata, s == 1 ? data_wdata : inst_wdata);
      chk("mem_ctl", {mem_wr, mem_size, mem_wstrb},
          s == 1 ? {data_wr, data_size, data_wstrb} : {inst_wr, inst_size, inst_wstrb});
    end
    if (pop_i) chk("inst_rdata", inst_rdata, rd);
    if (pop_d) chk("data_rdata", data_rdata, rd);
    if (mdok) begin
      if (q.size() > 0) void'(q.pop_front());
      else perr = 1'b1;
    end
    if (mreq && maok) q.push_back(s[0]);
    starve = (!ir || (mreq && maok && s == 0)) ? 0 : (starve < LIM ? starve + 1 : LIM);
    held = (mreq && !maok) ? s : -1;
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    reset = 1'b1;
    inst_req = 1'b0;
    data_req = 1'b0;
    mem_addr_ok = 1'b0;
    mem_data_ok = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    q.delete();
    starve = 0;
    held = -1;
    perr = 1'b0;
  endtask
  initial begin
    int hit;
    bit ip, dp;
    inst_req = 0; data_req = 0; mem_addr_ok = 0; mem_data_ok = 0; mem_rdata = 0;
    inst_wr = 0; inst_size = 2'd2; inst_wstrb = 4'hf; inst_wdata = 0; inst_addr = 32'hbfc00000;
    data_wr = 0; data_size = 2'd2; data_wstrb = 4'hf; data_wdata = 0; data_addr = 32'h80001000;
    repeat (2) @(posedge clk);
    #1;
    do_reset();
    step(0, 0, 0, 0, 0);
    chk("rst_mreq", s_mreq, 0);
    chk("rst_perr", s_perr, 0);
    step(1, 0, 1, 0, 0);
    chk("fetch_aok", s_iaok, 1);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 32'h3c010001);
    chk("fetch_dok", s_idok, 1);
    chk("fetch_rdata", s_irdata, 32'h3c010001);
    chk("fetch_no_ddok", s_ddok, 0);
    step(1, 1, 1, 0, 0);
    chk("sim_data_first", s_daok, 1);
    chk("sim_inst_wait", s_iaok, 0);
    step(1, 0, 1, 0, 0);
    chk("sim_inst_second", s_iaok, 1);
    step(0, 0, 0, 1, 32'h11);
    chk("sim_rsp_data", s_ddok, 1);
    step(0, 0, 0, 1, 32'h22);
    chk("sim_rsp_inst", s_idok, 1);
    inst_addr = 32'hbfc00010;
    step(1, 0, 0, 0, 0);
    chk("lock_addr0", s_maddr, 32'hbfc00010);
    step(1, 1, 0, 0, 0);
    chk("lock_addr1", s_maddr, 32'hbfc00010);
    step(1, 1, 0, 0, 0);
    chk("lock_addr2", s_maddr, 32'hbfc00010);
    step(1, 1, 1, 0, 0);
    chk("lock_inst_aok", s_iaok, 1);
    chk("lock_data_wait", s_daok, 0);
    step(0, 1, 1, 0, 0);
    chk("lock_data_aok", s_daok, 1);
    step(1, 1, 1, 0, 0);
    chk("full_mreq", s_mreq, 0);
    step(1, 1, 1, 1, 32'h33);
    chk("full_mreq_pop", s_mreq, 0);
    step(1, 1, 1, 0, 0);
    chk("full_reopen", s_mreq, 1);
    chk("full_reopen_data", s_daok, 1);
    while (q.size() > 0) step(0, 0, 0, 1, $urandom);
    hit = -1;
    for (int i = 0; i < 12; i++) begin
      step(hit < 0, 1, 1, q.size() > 0, $urandom);
      if (hit >= 0 && i == hit + 1) chk("starve_resume", s_daok, 1);
      if (s_iaok && hit < 0) hit = i;
    end
    chk("starve_cycle", hit, 8);
    while (q.size() > 0) step(0, 0, 0, 1, $urandom);
    step(0, 0, 0, 1, 32'h44);
    chk("stray_idok", s_idok, 0);
    chk("stray_ddok", s_ddok, 0);
    step(0, 0, 0, 0, 0);
    chk("stray_perr", s_perr, 1);
    do_reset();
    step(0, 0, 0, 0, 0);
    chk("reset_perr", s_perr, 0);
    step(1, 0, 1, 0, 0);
    step(0, 1, 1, 0, 0);
    chk("reset_cnt_2nd", s_daok, 1);
    step(1, 1, 1, 0, 0);
    chk("reset_cnt_full", s_mreq, 0);
    while (q.size() > 0) step(0, 0, 0, 1, $urandom);
    ip = 0;
    dp = 0;
    for (int i = 0; i < 2000; i++) begin
      if ($urandom % 500 == 0) begin
        do_reset();
        ip = 0;
        dp = 0;
      end
      if (!ip && $urandom % 2 == 0) begin
        ip = 1;
        inst_addr = $urandom;
      end
      if (!dp && $urandom % 3 == 0) begin
        dp = 1;
        data_addr = $urandom;
        data_wdata = $urandom;
        data_wr = 1'($urandom % 2);
        data_size = 2'($urandom % 3);
        data_wstrb = 4'($urandom);
      end
      step(ip, dp, $urandom % 4 != 0, q.size() > 0 && $urandom % 2 == 0, $urandom);
      if (s_iaok) ip = 0;
      if (s_daok) dp = 0;
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
